// File: rtl/switch_debounce_irq_ctrl.sv
// ---------------------------------------------------------------------------
// switch_debounce_irq_ctrl
//
// Avalon-MM slave that presents the alarm clock's slide switches to the
// Nios II. Each raw switch is brought into the clk domain by a two-flop
// synchroniser. It is then debounced: a new level is accepted only after it
// has been seen for DEBOUNCE_CYCLES consecutive clocks. Every accepted change,
// rising or falling, is latched in a write-1-to-clear edge-capture register.
// A maskable level interrupt is raised so firmware does not have to poll.
//
// Register map (32-bit words, PIO-compatible):
//   0  data        RO   debounced switch levels, zero-extended
//   1  reserved         reads 0, writes ignored
//   2  irqmask     RW   bits [WIDTH-1:0]
//   3  edgecapture W1C  latched edges; writing 1 to a bit clears it
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, valid one clock after address
//   in_port     raw asynchronous switch levels
//   irq         level interrupt, |(edgecapture & irqmask)
// ---------------------------------------------------------------------------
module switch_debounce_irq_ctrl #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Count value held on the last mismatching cycle before a level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] db;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] w1c_clear;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             wdata_unused;

  // Only the low WIDTH bits of writedata carry meaning.
  assign wdata_unused = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign w1c_clear = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0]
                                                        : '0;

  // -------------------------------------------------------------------------
  // Synchroniser
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its source; with blocking '=' the two synchroniser
  // stages would collapse into a single flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync_q <= '0;
    end else begin
      sync1  <= in_port;
      sync_q <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce
  // The per-bit STABLE/PENDING state is not stored separately: a bit is
  // PENDING exactly when sync_q differs from db, and cnt counts how long it
  // has been so. Returning to db before acceptance zeroes the count.
  // -------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before any
  // conditional logic, so no path leaves a value unassigned and no latch is
  // inferred.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync_q[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          accept[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the counter array is reset explicitly. It holds control state, not
  // data, so a pending count must be discarded on reset rather than left to
  // resume from a stale value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      db <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      db <= db ^ accept;
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // On a collision between an accepted edge and a W1C of the same bit, the
  // set term is ORed in after the clear, so the new edge is not lost.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      edgecapture <= (edgecapture & ~w1c_clear) | accept;
    end
  end

  // -------------------------------------------------------------------------
  // Read path: registered every clock, independent of chipselect.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = db;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_switch_debounce_irq_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for switch_debounce_irq_ctrl (WIDTH=2, DEBOUNCE_CYCLES=4).
// A behavioural model states the debounce rule directly: a bit takes a new
// level once the last DEBOUNCE_CYCLES synchronised samples all differ from
// the current debounced level. The model is compared with readdata and irq on
// every falling edge. The directed scenarios add literal expectations.
// Inputs change 1 time unit after a falling edge.
// ---------------------------------------------------------------------------
module tb_switch_debounce_irq_ctrl;

  localparam int W = 2;
  localparam int D = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b1;
  logic [1:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port    = '0;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  switch_debounce_irq_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  logic [W-1:0] m_sync1 = '0;
  logic [W-1:0] m_sync  = '0;
  logic [W-1:0] m_db    = '0;
  logic [W-1:0] m_mask  = '0;
  logic [W-1:0] m_ec    = '0;
  logic [31:0]  m_rd    = '0;
  logic [W-1:0] m_hist[$];

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_sync1 = '0;
        m_sync  = '0;
        m_db    = '0;
        m_mask  = '0;
        m_ec    = '0;
        m_rd    = '0;
        m_hist.delete();
      end else begin
        logic [W-1:0] new_db;
        logic [W-1:0] changed;
        bit           all_diff;
        // Read data reflects the register contents before this edge.
        case (address)
          2'd0:    m_rd = 32'(m_db);
          2'd2:    m_rd = 32'(m_mask);
          2'd3:    m_rd = 32'(m_ec);
          default: m_rd = '0;
        endcase
        m_hist.push_back(m_sync);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        new_db = m_db;
        if (m_hist.size() == D) begin
          for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) new_db[b] = ~m_db[b];
          end
        end
        changed = new_db ^ m_db;
        if (chipselect && !write_n && address == 2'd3)
          m_ec = (m_ec & ~writedata[W-1:0]) | changed;
        else
          m_ec = m_ec | changed;
        if (chipselect && !write_n && address == 2'd2)
          m_mask = writedata[W-1:0];
        m_db    = new_db;
        m_sync  = m_sync1;
        m_sync1 = in_port;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cycle_readdata", readdata, m_rd);
        check("cycle_irq", 32'(irq), 32'(|(m_ec & m_mask)));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Bus helpers
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    step(1);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  // Watchdog: the directed sequence needs only a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] v;

    // 1. Reset state.
    #2 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    step(2);
    reset_n = 1'b1;
    step(1);
    bus_read(2'd0, v); check("rst_data", v, 32'h0);
    bus_read(2'd2, v); check("rst_irqmask", v, 32'h0);
    bus_read(2'd3, v); check("rst_edgecap", v, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // 2. Clean rising step on bit 0: db updates on the 6th edge, so the
    //    registered data read shows it one edge later.
    address = 2'd0;
    in_port = 2'b01;
    step(6);
    check("step_data_edge6", readdata, 32'h0);
    step(1);
    check("step_data_edge7", readdata, 32'h1);
    bus_read(2'd3, v); check("step_edgecap", v, 32'h1);
    check("step_irq_masked", 32'(irq), 32'h0);

    // 3. Bit 1 bounces with 2-cycle pulses, never long enough to accept.
    for (int k = 0; k < 4; k++) begin
      in_port = (k % 2 == 0) ? 2'b11 : 2'b01;
      step(2);
    end
    in_port = 2'b01;
    step(8);
    bus_read(2'd0, v); check("bounce_data", v, 32'h1);
    bus_read(2'd3, v); check("bounce_edgecap", v, 32'h1);

    // 4. Interrupt raise and W1C clear.
    bus_write(2'd3, 32'h1);
    bus_write(2'd2, 32'h3);
    check("mask_irq_idle", 32'(irq), 32'h0);
    bus_read(2'd2, v); check("mask_readback", v, 32'h3);
    in_port = 2'b11;
    step(8);
    bus_read(2'd3, v); check("irq_edgecap", v, 32'h2);
    check("irq_high", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h2);
    check("irq_cleared", 32'(irq), 32'h0);
    bus_read(2'd3, v); check("w1c_readback", v, 32'h0);

    // 5. W1C of bit 0 on the very edge its falling level is accepted.
    in_port = 2'b10;
    step(5);
    check("collide_irq_before", 32'(irq), 32'h0);
    bus_write(2'd3, 32'h1);
    check("collide_irq_after", 32'(irq), 32'h1);
    bus_read(2'd3, v); check("collide_edgecap", v, 32'h1);
    bus_read(2'd0, v); check("collide_data", v, 32'h2);

    // 6. Reset two cycles into a pending change with both switches high.
    bus_write(2'd3, 32'h3);
    in_port = 2'b11;
    step(4);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    address = 2'd0;
    step(6);
    check("rstpend_data_edge6", readdata, 32'h0);
    step(1);
    check("rstpend_data_edge7", readdata, 32'h3);
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, v); check("data_write_ignored", v, 32'h3);
    bus_read(2'd3, v); check("rstpend_edgecap", v, 32'h3);
    bus_read(2'd2, v); check("rstpend_irqmask", v, 32'h0);
    bus_read(2'd1, v); check("reserved_zero", v, 32'h0);
    check("rstpend_irq", 32'(irq), 32'h0);

    step(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
